// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter: N producers share one sync-FIFO write port, with
// bounded bursts per owner. Each written word carries its source ID.
module fifo_wr_arbiter #(
    parameter int NREQ      = 4,
    parameter int DWIDTH    = 16,
    parameter int MAX_BURST = 4,
    localparam int IDW      = $clog2(NREQ)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*DWIDTH-1:0]   req_data,
    output logic [NREQ-1:0]          req_ready,
    input  logic                     fifo_full,
    output logic                     fifo_wr_en,
    output logic [IDW+DWIDTH-1:0]    fifo_din,
    output logic                     grant_valid,
    output logic [IDW-1:0]           grant_id
);

    localparam int BCW = $clog2(MAX_BURST + 1);

    typedef enum logic {S_IDLE, S_BURST} state_t;

    state_t           state_q, state_d;
    logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0]   owner_q, owner_d;
    logic [BCW-1:0]   beat_cnt_q, beat_cnt_d;

    logic             elig;
    logic [IDW-1:0]   sel;
    logic [IDW:0]     idx;
    logic [IDW-1:0]   rr_next;
    logic [DWIDTH-1:0] data_arr [NREQ];

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_port
            assign data_arr[gi]  = req_data[gi*DWIDTH +: DWIDTH];
            assign req_ready[gi] = fifo_wr_en && (grant_id == IDW'(gi));
        end
    endgenerate

    // Eligible producer: the burst owner while it stays valid, otherwise a
    // wrapping search from rr_ptr (explicit modulo keeps non-pow2 NREQ in range).
    always_comb begin
        elig = 1'b0;
        sel  = '0;
        idx  = '0;
        if (state_q == S_BURST) begin
            elig = req_valid[owner_q];
            sel  = owner_q;
        end else begin
            for (int k = 0; k < NREQ; k++) begin
                idx = {1'b0, rr_ptr_q} + (IDW+1)'(k);
                if (idx >= (IDW+1)'(NREQ))
                    idx = idx - (IDW+1)'(NREQ);
                if (!elig && req_valid[idx[IDW-1:0]]) begin
                    elig = 1'b1;
                    sel  = idx[IDW-1:0];
                end
            end
        end
    end

    assign grant_valid = elig && !rst;
    assign grant_id    = grant_valid ? sel : '0;
    assign fifo_wr_en  = grant_valid && !fifo_full;
    assign fifo_din    = {grant_id, data_arr[grant_id]};
    assign rr_next     = (sel == IDW'(NREQ - 1)) ? '0 : sel + IDW'(1);

    // A full FIFO freezes everything, so a stall never eats burst budget.
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        owner_d    = owner_q;
        beat_cnt_d = beat_cnt_q;
        if (!fifo_full) begin
            case (state_q)
                S_IDLE: begin
                    if (elig) begin
                        rr_ptr_d   = rr_next;
                        owner_d    = sel;
                        beat_cnt_d = BCW'(1);
                        state_d    = (MAX_BURST > 1) ? S_BURST : S_IDLE;
                    end
                end
                S_BURST: begin
                    if (elig) begin
                        beat_cnt_d = beat_cnt_q + BCW'(1);
                        if (beat_cnt_d == BCW'(MAX_BURST))
                            state_d = S_IDLE;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            rr_ptr_q   <= '0;
            owner_q    <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            owner_q    <= owner_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: three configurations (4x burst4, 4x burst1, 3x burst1)
// driven cycle by cycle; expected outputs queued at drive time, checked at negedge.
module tb_fifo_wr_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic [3:0]  valid_a = '0, valid_b = '0;
    logic [2:0]  valid_c = '0;
    logic [63:0] data_a = '0, data_b = '0;
    logic [47:0] data_c = '0;
    logic        full_a = 1'b0, full_b = 1'b0, full_c = 1'b0;

    logic [3:0]  ready_a, ready_b;
    logic [2:0]  ready_c;
    logic        wr_a, wr_b, wr_c;
    logic [17:0] din_a, din_b, din_c;
    logic        gv_a, gv_b, gv_c;
    logic [1:0]  id_a, id_b, id_c;

    int n_vec  = 0;
    int n_miss = 0;
    int cyc    = 0;

    typedef struct {
        int          dut;
        string       tag;
        logic        wr;
        logic        gv;
        int          id;
        logic [15:0] rdy;
        logic [17:0] din;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    fifo_wr_arbiter #(.NREQ(4), .DWIDTH(16), .MAX_BURST(4)) u_a (
        .clk(clk), .rst(rst), .req_valid(valid_a), .req_data(data_a),
        .req_ready(ready_a), .fifo_full(full_a), .fifo_wr_en(wr_a),
        .fifo_din(din_a), .grant_valid(gv_a), .grant_id(id_a)
    );

    fifo_wr_arbiter #(.NREQ(4), .DWIDTH(16), .MAX_BURST(1)) u_b (
        .clk(clk), .rst(rst), .req_valid(valid_b), .req_data(data_b),
        .req_ready(ready_b), .fifo_full(full_b), .fifo_wr_en(wr_b),
        .fifo_din(din_b), .grant_valid(gv_b), .grant_id(id_b)
    );

    fifo_wr_arbiter #(.NREQ(3), .DWIDTH(16), .MAX_BURST(1)) u_c (
        .clk(clk), .rst(rst), .req_valid(valid_c), .req_data(data_c),
        .req_ready(ready_c), .fifo_full(full_c), .fifo_wr_en(wr_c),
        .fifo_din(din_c), .grant_valid(gv_c), .grant_id(id_c)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    function automatic logic [15:0] mkdata(input int i, input int c);
        logic [3:0]  hi;
        logic [11:0] lo;
        hi = 4'(i + 1);
        lo = 12'(c);
        return {hi, lo};
    endfunction

    task automatic step(input int dut, input string tag, input logic r, input logic [3:0] v,
                        input logic f, input logic ewr, input logic egv, input int eid);
        exp_t e;
        @(posedge clk);
        #1;
        cyc++;
        rst     = r;
        valid_a = (dut == 0) ? v : 4'b0;
        valid_b = (dut == 1) ? v : 4'b0;
        valid_c = (dut == 2) ? v[2:0] : 3'b0;
        full_a  = (dut == 0) ? f : 1'b0;
        full_b  = (dut == 1) ? f : 1'b0;
        full_c  = (dut == 2) ? f : 1'b0;
        for (int i = 0; i < 4; i++) begin
            data_a[i*16 +: 16] = mkdata(i, cyc);
            data_b[i*16 +: 16] = mkdata(i, cyc);
        end
        for (int i = 0; i < 3; i++)
            data_c[i*16 +: 16] = mkdata(i, cyc);
        e.dut = dut;
        e.tag = tag;
        e.wr  = ewr;
        e.gv  = egv;
        e.id  = eid;
        e.rdy = ewr ? (16'd1 << eid) : 16'd0;
        e.din = {eid[1:0], mkdata(eid, cyc)};
        sb.push_back(e);
    endtask

    exp_t        ce;
    logic        o_wr, o_gv;
    logic [1:0]  o_id;
    logic [15:0] o_rdy;
    logic [17:0] o_din;

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            ce = sb.pop_front();
            case (ce.dut)
                0:       begin o_wr = wr_a; o_gv = gv_a; o_id = id_a; o_rdy = 16'(ready_a); o_din = din_a; end
                1:       begin o_wr = wr_b; o_gv = gv_b; o_id = id_b; o_rdy = 16'(ready_b); o_din = din_b; end
                default: begin o_wr = wr_c; o_gv = gv_c; o_id = id_c; o_rdy = 16'(ready_c); o_din = din_c; end
            endcase
            check_val($sformatf("%s/wr_en", ce.tag), 32'(o_wr),  32'(ce.wr));
            check_val($sformatf("%s/gvalid", ce.tag), 32'(o_gv), 32'(ce.gv));
            check_val($sformatf("%s/gid", ce.tag), 32'(o_id),    32'(ce.id));
            check_val($sformatf("%s/ready", ce.tag), 32'(o_rdy), 32'(ce.rdy));
            if (ce.wr)
                check_val($sformatf("%s/din", ce.tag), 32'(o_din), 32'(ce.din));
        end
    end

    initial begin
        // reset with everything requesting: outputs must be quiet
        step(0, "reset", 1'b1, 4'hF, 1'b0, 1'b0, 1'b0, 0);
        step(0, "reset", 1'b1, 4'hF, 1'b0, 1'b0, 1'b0, 0);

        // full-load rotation, 4 beats per owner
        for (int k = 0; k < 16; k++)
            step(0, "rr4", 1'b0, 4'hF, 1'b0, 1'b1, 1'b1, k / 4);

        // producer 1: two beats, three stalled cycles, then exactly two more
        step(0, "b1", 1'b0, 4'b0010, 1'b0, 1'b1, 1'b1, 1);
        step(0, "b1", 1'b0, 4'b0010, 1'b0, 1'b1, 1'b1, 1);
        for (int k = 0; k < 3; k++)
            step(0, "stall", 1'b0, 4'b0010, 1'b1, 1'b0, 1'b1, 1);
        step(0, "b1", 1'b0, 4'b0010, 1'b0, 1'b1, 1'b1, 1);
        step(0, "b1", 1'b0, 4'b0010, 1'b0, 1'b1, 1'b1, 1);
        step(0, "post_b1", 1'b0, 4'b0011, 1'b0, 1'b1, 1'b1, 0);

        // owner drops out -> one empty cycle, back to arbitration
        step(0, "gap", 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 0);
        step(0, "p2", 1'b0, 4'b0100, 1'b0, 1'b1, 1'b1, 2);
        step(0, "drop", 1'b0, 4'b1000, 1'b0, 1'b0, 1'b0, 0);
        step(0, "p3", 1'b0, 4'b1000, 1'b0, 1'b1, 1'b1, 3);

        // reset in the middle of producer 3's burst
        step(0, "p3b", 1'b0, 4'hF, 1'b0, 1'b1, 1'b1, 3);
        step(0, "midrst", 1'b1, 4'hF, 1'b0, 1'b0, 1'b0, 0);
        step(0, "post_rst", 1'b0, 4'hF, 1'b0, 1'b1, 1'b1, 0);
        step(0, "post_rst", 1'b0, 4'hF, 1'b0, 1'b1, 1'b1, 0);

        // single-beat bursts alternate between producers 0 and 2
        for (int k = 0; k < 4; k++)
            step(1, "mb1", 1'b0, 4'b0101, 1'b0, 1'b1, 1'b1, (k % 2 == 0) ? 0 : 2);

        // three ports, pointer wraps 2 -> 0
        for (int k = 0; k < 4; k++)
            step(2, "n3", 1'b0, 4'b0100, 1'b0, 1'b1, 1'b1, 2);
        step(2, "wrap", 1'b0, 4'b0011, 1'b0, 1'b1, 1'b1, 0);
        step(2, "wrap", 1'b0, 4'b0011, 1'b0, 1'b1, 1'b1, 1);

        @(negedge clk);
        #1;
        check_val("sb_drain", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 SHALL provide parameter NREQ, default 4, number of producer ports (2..16).
REQ-002 SHALL provide parameter DWIDTH, default 16, producer data width in bits.
REQ-003 SHALL provide parameter MAX_BURST, default 4, maximum consecutive beats granted to one owner (1..16).
REQ-004 SHALL define localparam IDW = $clog2(NREQ), the source-ID width.
REQ-005 SHALL have port clk, input, 1 bit: single system clock; all state updates occur on the rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-007 SHALL have port req_valid, input, NREQ bits: per-producer data-valid.
REQ-008 SHALL have port req_data, input, NREQ*DWIDTH bits: producer i occupies bits [i*DWIDTH +: DWIDTH].
REQ-009 SHALL have port req_ready, output, NREQ bits: per-producer accept; a beat transfers when req_valid[i] && req_ready[i].
REQ-010 SHALL have port fifo_full, input, 1 bit: full flag of the downstream sync FIFO.
REQ-011 SHALL have port fifo_wr_en, output, 1 bit: write strobe to the FIFO.
REQ-012 SHALL have port fifo_din, output, IDW+DWIDTH bits: {source ID, data} written to the FIFO.
REQ-013 SHALL have port grant_valid, output, 1 bit: an eligible producer exists this cycle.
REQ-014 SHALL have port grant_id, output, IDW bits: index of the eligible producer; 0 when grant_valid is 0.

Function
REQ-015 SHALL implement a two-state FSM (IDLE, BURST) with registers rr_ptr (IDW bits), owner (IDW bits) and beat_cnt ($clog2(MAX_BURST+1) bits).
REQ-016 In IDLE, the eligible producer SHALL be the first i with req_valid[i]=1, searching from rr_ptr upward and wrapping modulo NREQ.
REQ-017 In BURST, the eligible producer SHALL be owner, and only while req_valid[owner]=1.
REQ-018 req_ready[i] SHALL be 1 only for the eligible producer, and only when fifo_full=0 and rst=0.
REQ-019 fifo_wr_en SHALL equal the transfer condition of the eligible producer, combinationally (zero-cycle latency); fifo_din SHALL be {grant_id, req_data of grant_id}.
REQ-020 On an IDLE transfer by producer c: rr_ptr <= (c+1) mod NREQ, owner <= c, beat_cnt <= 1, and the FSM goes to BURST if MAX_BURST>1, else stays IDLE.
REQ-021 On a BURST transfer: beat_cnt <= beat_cnt+1; if beat_cnt+1 == MAX_BURST, the FSM goes to IDLE.
REQ-022 In BURST with req_valid[owner]=0: no transfer that cycle, and the FSM goes to IDLE the next cycle.
REQ-023 In either state with fifo_full=1: no transfer, and FSM, rr_ptr, owner and beat_cnt hold; a stall SHALL NOT consume burst count.
REQ-024 At most one producer SHALL transfer per cycle, and fifo_wr_en SHALL never assert while fifo_full=1.
REQ-025 When non-owner producers assert req_valid during a burst, they SHALL be ignored until the FSM returns to IDLE.
REQ-026 rr_ptr wrap from NREQ-1 SHALL go to 0 for any NREQ, including non-power-of-two values.
REQ-027 The block SHALL hold no data storage; the source ID is carried in fifo_din so the consumer can demultiplex.

Reset
REQ-028 While rst=1 at a clock edge, the FSM SHALL go to IDLE with rr_ptr=0, owner=0 and beat_cnt=0.
REQ-029 While rst=1, req_ready, fifo_wr_en, grant_valid and grant_id SHALL all be 0, regardless of other inputs.
REQ-030 Reset asserted mid-burst SHALL abandon the burst; the first grant after reset SHALL be resolved from rr_ptr=0.

Verification
REQ-031 NREQ=4, MAX_BURST=4, all req_valid=1, fifo_full=0 for 16 cycles -> grant_id sequence 0,0,0,0,1,1,1,1,2,2,2,2,3,3,3,3.
REQ-032 MAX_BURST=1, req_valid=4'b0101 held -> grant_id alternates 0,2,0,2; fifo_din ID field matches grant_id each cycle.
REQ-033 Producer 1 in BURST after 2 beats, then fifo_full=1 for 3 cycles -> fifo_wr_en=0 and req_ready=0 for those cycles; after fifo_full drops, exactly 2 more beats from producer 1 are written.
REQ-034 Producer 2 drops req_valid after 1 beat while producer 3 is valid -> one idle cycle with no write, then producer 3 is granted.
REQ-035 rst=1 asserted for 1 cycle mid-burst of producer 3 with all producers valid -> outputs are 0 during reset; the first grant after reset goes to producer 0.
REQ-036 NREQ=3, only producer 2 valid, MAX_BURST=1 -> repeated grants to producer 2; rr_ptr wraps 2->0 with no X or out-of-range ID.
